// File: rtl/prefix_seq_pkg.sv
// Shared types and constants for the iterative prefix-adder sequencer.
package prefix_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        SUM    = 2'd2,
        DONE   = 2'd3
    } prefixState_e;

    // Holds level indices 0..5, enough for WIDTH up to 64.
    localparam int LVL_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_level_row.sv
// One Kogge-Stone level of group generate/propagate cells, span selected at run time.
module prefix_level_row
    import prefix_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [LVL_W-1:0] lvl,
    output logic [WIDTH-1:0] gNext,
    output logic [WIDTH-1:0] pNext
);

    int spanInt;
    logic [WIDTH-1:0] gShift;
    logic [WIDTH-1:0] pShift;

    // Below 2*span the lower group already reaches bit 0, so only G needs combining (gray cell).
    always_comb begin
        spanInt = 1 << lvl;
        gShift  = g << spanInt;
        pShift  = p << spanInt;
        gNext   = g;
        pNext   = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= spanInt) begin
                gNext[i] = g[i] | (p[i] & gShift[i]);
                if (i >= 2 * spanInt) begin
                    pNext[i] = p[i] & pShift[i];
                end
            end
        end
    end

endmodule

// File: rtl/prefix_add_sequencer.sv
// Iterative parallel-prefix adder: one Kogge-Stone level per clock, result held until taken.
// Optional macro PREFIX_SEQ_BACK_TO_BACK_EN lets a new add be accepted on the retire edge.
module prefix_add_sequencer
    import prefix_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int LOG2W = clog2(WIDTH);
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LOG2W - 1);

    prefixState_e     state;
    logic [LVL_W-1:0] lvl;
    logic [WIDTH-1:0] gReg;
    logic [WIDTH-1:0] pReg;
    logic [WIDTH-1:0] p0Reg;
    logic [WIDTH-1:0] gNext;
    logic [WIDTH-1:0] pNext;
    logic [WIDTH-1:0] gInit;
    logic             cinReg;
    logic             accept;

    // Fold carry-in into bit 0 so the prefix tree needs no separate carry path.
    always_comb begin
        gInit    = a & b;
        gInit[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    end

`ifdef PREFIX_SEQ_BACK_TO_BACK_EN
    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
`else
    assign in_ready = ~rst & (state == IDLE);
`endif

    assign accept = in_valid & in_ready;
    assign busy   = (state == PREFIX) | (state == SUM);

    prefix_level_row #(.WIDTH(WIDTH)) uRow (
        .g     (gReg),
        .p     (pReg),
        .lvl   (lvl),
        .gNext (gNext),
        .pNext (pNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lvl       <= '0;
            gReg      <= '0;
            pReg      <= '0;
            p0Reg     <= '0;
            cinReg    <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                PREFIX: begin
                    gReg <= gNext;
                    pReg <= pNext;
                    if (lvl == LAST_LVL) begin
                        lvl   <= '0;
                        state <= SUM;
                    end else begin
                        lvl <= lvl + 1'b1;
                    end
                end
                SUM: begin
                    sum       <= p0Reg ^ {gReg[WIDTH-2:0], cinReg};
                    cout      <= gReg[WIDTH-1];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept can only fire in IDLE or on the retire edge, so it overrides the DONE exit.
            if (accept) begin
                gReg   <= gInit;
                pReg   <= a ^ b;
                p0Reg  <= a ^ b;
                cinReg <= cin;
                lvl    <= '0;
                state  <= PREFIX;
            end
        end
    end

endmodule

// File: tb/tb_prefix_add_sequencer.sv
// Directed and randomized bench for prefix_add_sequencer at WIDTH=16.
module tb_prefix_add_sequencer;

    localparam int WIDTH = 16;
`ifdef PREFIX_SEQ_BACK_TO_BACK_EN
    localparam int EXP_II = 6;
`else
    localparam int EXP_II = 7;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int testsRun    = 0;
    int testsFailed = 0;

    prefix_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runAdd(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] expSum, input logic expCout);
        int lat;
        a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check({tag, "_inready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_sum"}, 32'(sum), 32'(expSum));
        check({tag, "_cout"}, 32'(cout), 32'(expCout));
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int last;
        int nRes;
        int nDone;
        logic acc;
        logic ret;
        logic [16:0] expV;
        logic [16:0] q[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outvalid", 32'(out_valid), 32'd0);
        check("rst_inready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_inready", 32'(in_ready), 32'd1);

        runAdd("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1); retire("ffff_1");
        runAdd("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0); retire("1234_4321");
        runAdd("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1); retire("8000_8000");
        runAdd("zero_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0); retire("zero_cin");

        // Backpressure: result must hold while new operands are offered.
        runAdd("bp", 16'h00AA, 16'h0055, 1'b0, 16'h00FF, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'(i * 16'h1111); b = 16'(16'hF0F0 ^ i); cin = 1'(i);
            tick();
            check("bp_outvalid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h00FF);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_inready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        retire("bp");
        check("bp_idle_inready", 32'(in_ready), 32'd1);
        runAdd("after_bp", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0); retire("after_bp");

        // Reset in the second PREFIX cycle.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_outvalid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_inready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_release_inready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_discarded", 32'(out_valid), 32'd0);
        end
        runAdd("fresh", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0); retire("fresh");

        // Throughput with both handshakes held high.
        a = 16'h1000; b = 16'h0234; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; last = 0; nRes = 0;
        while (nRes < 5 && cyc < 80) begin
            tick();
            cyc++;
            if (out_valid) begin
                check("ii_sum", 32'(sum), 32'h1234);
                if (nRes > 0) check("ii_interval", 32'(cyc - last), 32'(EXP_II));
                last = cyc;
                nRes++;
            end
        end
        check("ii_results", 32'(nRes), 32'd5);
        in_valid = 1'b0;
        repeat (12) tick();
        out_ready = 1'b0;
        check("ii_drained", 32'(out_valid | busy), 32'd0);

        // Random traffic with stalls, checked in order against a scoreboard.
        cyc = 0; nDone = 0;
        while (nDone < 1000 && cyc < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            #1;
            acc = in_valid & in_ready;
            ret = out_valid & out_ready;
            if (ret) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 32'(q.size()), 32'd1);
                end else begin
                    expV = q.pop_front();
                    check("rnd_result", 32'({cout, sum}), 32'(expV));
                end
                nDone++;
            end
            if (acc) q.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
            tick();
            cyc++;
        end
        check("rnd_count", 32'(nDone), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/prefix_add_sequencer.md
# prefix_add_sequencer

Iterative parallel-prefix adder controller for the tree-adders library. It accepts one WIDTH-bit add per valid/ready handshake and time-multiplexes a single row of group-generate/propagate cells across log2(WIDTH) Kogge-Stone levels, one level per clock. It then forms sum and carry-out and holds the result until the consumer takes it. It trades latency for area relative to the fully unrolled tree adders.

## Interface
- WIDTH, 16: operand width; power of two, 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a/b/cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend.
- b  in  WIDTH  addend.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a+b+cin, low WIDTH bits.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in PREFIX or SUM state.

## Operation
- LOG2W = log2(WIDTH).
- States: IDLE, PREFIX, SUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - p0 = a^b, stored unchanged for the sum.
    - P = a^b.
    - G = a&b, with G[0] = a[0]&b[0] | (a[0]^b[0])&cin.
    - Latch cin.
    - lvl=0; go to PREFIX.
- PREFIX:
  - Each edge applies level lvl with span s = 2^lvl.
  - For i>=s: G[i] |= P[i]&G[i-s] and P[i] &= P[i-s]. For i<s: unchanged.
  - lvl increments. After the level lvl=LOG2W-1, go to SUM.
- SUM:
  - One edge registers sum[0] = p0[0]^cin, sum[i] = p0[i]^G[i-1] for i>=1, and cout = G[WIDTH-1].
  - out_valid is set; go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid clears and the state returns to IDLE.
- in_valid outside IDLE is ignored; operands are not sampled. Exception: the macro case in Configuration.
- a/b/cin are sampled only on the accept edge. Later changes have no effect.
- Reset, asynchronous and at any point including mid-PREFIX:
  - state=IDLE, lvl=0, G=P=p0=0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high; 1 in the first cycle after deassertion.
  - Any in-flight operation is discarded.
- Arithmetic is modulo 2^WIDTH; the overflow bit appears only on cout.

## Timing
- Accept edge E0. PREFIX edges E1..E_LOG2W. SUM edge E_(LOG2W+1).
- out_valid is visible after E_(LOG2W+1), i.e. latency LOG2W+1 cycles. WIDTH=16 gives 5.
- Without the macro, with out_ready held high, the initiation interval is LOG2W+3 cycles: 7 for WIDTH=16.
- in_ready and busy are decoded combinationally from state. All other outputs are registered.
- out_valid never drops without out_ready. sum/cout never change while out_valid=1.

## Configuration
- PREFIX_SEQ_BACK_TO_BACK_EN:
  - When defined, in DONE, in_ready = out_ready.
  - A simultaneous out handshake and in handshake on the same edge retires the result and loads the new operands directly into PREFIX. This removes the IDLE bubble, giving an interval of LOG2W+2 (6 for WIDTH=16).
  - When undefined, in_ready is 1 only in IDLE.

## Structure
- Package prefix_seq_pkg holds:
  - state enum (IDLE, PREFIX, SUM, DONE);
  - a clog2-style constant function for LOG2W;
  - the level-counter width constant.
- Sub-module prefix_level_row: combinational.
  - Inputs: G, P, span index lvl.
  - Outputs: next G, next P.
  - Built from per-bit black cells (G and P) and gray cells (G only) for positions i<2*s.
- The controller owns all registers, the FSM and the sum/cout formation.

## Test plan
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, out_valid rising exactly 5 cycles after the accept edge.
- a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0. Then a=16'h8000, b=16'h8000, cin=0 → sum=16'h0000, cout=1. Then a=0, b=0, cin=1 → sum=16'h0001, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and changing a/b → sum/cout stable, in_ready=0, no new accept. out_ready=1 → retire, then accept in IDLE.
- Assert rst in the second PREFIX cycle → out_valid=0, sum=0, cout=0, busy=0 immediately. After deassertion in_ready=1, and a fresh add 16'h00FF+16'h0001 → 16'h0100.
- Random a/b/cin, 1000 transactions, random in_valid/out_ready stalls → every result equals {cout,sum} = a+b+cin, in order, none dropped or duplicated.
- With PREFIX_SEQ_BACK_TO_BACK_EN, in_valid and out_ready held 1 → results every 6 cycles. Without the macro → every 7 cycles.
